// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte producers.
// A grant in IDLE latches the byte and starts the frame on the next edge; txd comes straight from a flop.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int ID_W         = 2
) (
    input  logic                   system_clk,
    input  logic                   reset_n,
    input  logic                   system_clk_locked,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart0_txd,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);

    localparam int NUM_SLOTS = 2 ** ID_W;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ID_W:0]     NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     grant_id_reg;
    logic [7:0]          shift_reg;
    logic [BAUD_W-1:0]   baud_cnt_reg;
    logic [2:0]          bit_cnt_reg;
    logic                txd_reg;

    logic                grant;
    logic                sel_found;
    logic [ID_W-1:0]     sel_idx;
    logic [ID_W:0]       cand;
    logic                baud_end;

    // Pad requests and bytes to a power of two so unused slots can never win.
    logic [NUM_SLOTS-1:0] valid_ext;
    logic [7:0]           req_bytes [NUM_SLOTS];

    assign valid_ext = NUM_SLOTS'(req_valid);

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_bytes
            if (gi < NUM_REQ) begin : g_real
                assign req_bytes[gi] = req_data[8*gi +: 8];
            end else begin : g_pad
                assign req_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_reg} + (ID_W + 1)'(off);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!sel_found && valid_ext[cand[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign baud_end = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (grant) state_next = START;
            START: if (baud_end) state_next = DATA;
            DATA:  if (baud_end && bit_cnt_reg == 3'd7) state_next = STOP;
            STOP:  if (baud_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant = (state_reg == IDLE) && system_clk_locked && (|req_valid);
        busy  = (state_reg != IDLE);
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant && (sel_idx == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg      <= '0;
            grant_id_reg <= '0;
            shift_reg    <= '0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            txd_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    if (grant) begin
                        shift_reg    <= req_bytes[sel_idx];
                        grant_id_reg <= sel_idx;
                        ptr_reg      <= (sel_idx == LAST_ID) ? '0 : sel_idx + ID_W'(1);
                        txd_reg      <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        txd_reg      <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            txd_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            txd_reg     <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                STOP: begin
                    txd_reg <= 1'b1;
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                default: txd_reg <= 1'b1;
            endcase
        end
    end

    assign uart0_txd = txd_reg;
    assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: tests push expected (requester, byte) frames; a line monitor decodes
// frames from uart0_txd and pops/compares them, also checking busy length and frame spacing.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int IW  = 2;

    logic              system_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              system_clk_locked = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [8*NR-1:0]   req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              uart0_txd;
    logic              busy;
    logic [IW-1:0]     grant_id;

    uart_tx_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .ID_W(IW)) dut (
        .system_clk        (system_clk),
        .reset_n           (reset_n),
        .system_clk_locked (system_clk_locked),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .uart0_txd         (uart0_txd),
        .busy              (busy),
        .grant_id          (grant_id)
    );

    always #5 system_clk = ~system_clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(posedge system_clk) cyc <= cyc + 1;

    // Line monitor and grant tracker
    logic       in_frame = 1'b0;
    logic       prev_txd = 1'b1;
    logic       spacing_on = 1'b0;
    logic       fall_valid = 1'b0;
    int         ph = 0;
    int         busy_len = 0;
    int         last_fall = 0;
    int         grant_count = 0;
    int         last_grant = 0;
    int         grants_per [NR] = '{default: 0};
    logic [7:0] rx_byte = '0;

    always @(negedge system_clk) begin
        if (!reset_n) begin
            in_frame = 1'b0;
            ph       = 0;
            busy_len = 0;
            prev_txd = 1'b1;
        end else begin
            if (req_ready != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                check("ready_outside_idle", {31'b0, busy}, 0);
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) begin
                        last_grant = i;
                        grants_per[i]++;
                    end
                end
                grant_count++;
            end
            if (busy) begin
                busy_len++;
            end else if (busy_len != 0) begin
                check("busy_len", busy_len, 10 * CPB);
                busy_len = 0;
            end
            if (!in_frame && prev_txd && !uart0_txd) begin
                in_frame = 1'b1;
                ph = 0;
                if (spacing_on && fall_valid) check("frame_spacing", cyc - last_fall, 10 * CPB + 1);
                last_fall  = cyc;
                fall_valid = 1'b1;
            end else if (in_frame) begin
                ph++;
            end
            if (!spacing_on) fall_valid = 1'b0;
            if (in_frame && (ph % CPB) == CPB / 2) begin
                if (ph / CPB == 0) begin
                    check("start_bit", {31'b0, uart0_txd}, 0);
                end else if (ph / CPB <= 8) begin
                    rx_byte[ph / CPB - 1] = uart0_txd;
                end else begin
                    check("stop_bit", {31'b0, uart0_txd}, 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'b0, rx_byte}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("frame: id=%0d byte=0x%02h (expected id=%0d byte=0x%02h)",
                                 last_grant, rx_byte, e.id, e.data);
                        check("frame_byte", {24'b0, rx_byte}, {24'b0, e.data});
                        check("frame_req", last_grant, {30'b0, e.id});
                        check("grant_id", {30'b0, grant_id}, {30'b0, e.id});
                    end
                    in_frame = 1'b0;
                end
            end
            prev_txd = uart0_txd;
        end
    end

    task automatic push(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = IW'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Waits for req_ready[idx], then returns just after the accepting edge.
    task automatic wait_grant(input int idx, input string tag);
        int t;
        t = 0;
        @(negedge system_clk);
        while (!req_ready[idx] && t < 300) begin
            @(negedge system_clk);
            t++;
        end
        check(tag, {31'b0, req_ready[idx]}, 1);
        @(posedge system_clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(posedge system_clk);
            t++;
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int g;
        int g2;
        int t;

        repeat (3) @(posedge system_clk);
        #1;
        check("rst_txd", {31'b0, uart0_txd}, 1);
        check("rst_ready", {28'b0, req_ready}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_grant_id", {30'b0, grant_id}, 0);
        reset_n = 1'b1;
        system_clk_locked = 1'b1;
        @(posedge system_clk);
        #1;

        // Single byte 0xA5 from requester 0
        req_data[7:0] = 8'hA5;
        push(0, 8'hA5);
        req_valid = 4'b0001;
        wait_grant(0, "t1_grant");
        req_valid = '0;
        wait_drain("t1_drain");

        // Locked low holds off requester 1
        system_clk_locked = 1'b0;
        req_data[15:8] = 8'h3C;
        req_valid = 4'b0010;
        viol = 0;
        repeat (100) begin
            @(negedge system_clk);
            if (req_ready != '0 || uart0_txd !== 1'b1) viol++;
        end
        check("locked_holdoff", viol, 0);
        @(posedge system_clk);
        #1;
        system_clk_locked = 1'b1;
        push(1, 8'h3C);
        @(negedge system_clk);
        check("ready_after_lock", {28'b0, req_ready}, 32'h2);
        @(posedge system_clk);
        #1;
        req_valid = '0;
        wait_drain("lock_drain");

        // Lock drops mid-frame: frame completes, no new grant
        req_data[7:0] = 8'h0F;
        push(0, 8'h0F);
        req_valid = 4'b0001;
        wait_grant(0, "lockdrop_grant");
        repeat (24) @(posedge system_clk);
        #1;
        system_clk_locked = 1'b0;
        wait_drain("lockdrop_drain");
        g = grant_count;
        viol = 0;
        repeat (60) begin
            @(negedge system_clk);
            if (uart0_txd !== 1'b1) viol++;
        end
        check("no_grant_unlocked", grant_count - g, 0);
        check("line_idle_unlocked", viol, 0);
        req_valid = '0;
        @(posedge system_clk);
        #1;
        system_clk_locked = 1'b1;

        // Reset during data bit 3
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        wait_grant(0, "abort_grant");
        req_valid = '0;
        repeat (CPB + 3 * CPB + 2) @(posedge system_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_txd", {31'b0, uart0_txd}, 1);
        check("abort_busy", {31'b0, busy}, 0);
        repeat (2) @(posedge system_clk);
        #1;
        reset_n = 1'b1;
        req_data[31:24] = 8'hC3;
        push(3, 8'hC3);
        req_valid = 4'b1000;
        wait_grant(3, "after_reset_grant");
        req_valid = '0;
        @(negedge system_clk);
        check("after_reset_grant_id", {30'b0, grant_id}, 3);
        wait_drain("after_reset_drain");

        // All requesters valid: strict rotation, 41-cycle spacing
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        push(0, 8'h11);
        push(1, 8'h22);
        push(2, 8'h33);
        push(3, 8'h44);
        push(0, 8'h11);
        spacing_on = 1'b1;
        g = grant_count;
        req_valid = 4'b1111;
        t = 0;
        while (grant_count < g + 5 && t < 1000) begin
            @(posedge system_clk);
            t++;
        end
        check("rotation_grants", grant_count - g, 5);
        #1;
        // Requester 2 appears then withdraws while 0 is pending; pointer is now 1
        req_valid = 4'b0101;
        g2 = grants_per[2];
        repeat (10) @(posedge system_clk);
        #1;
        req_valid = 4'b0001;
        spacing_on = 1'b0;
        push(0, 8'h11);
        wait_grant(0, "withdraw_grant");
        req_valid = '0;
        wait_drain("final_drain");
        check("withdrawn_never_ready", grants_per[2] - g2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
